// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Iterative ALU for a processing core. An op and two operands are taken on a
//   start handshake. Single-cycle ops finish at the accepting edge. MUL (and DIV
//   when ALU_DIV_EN is defined) iterate WIDTH cycles. The result sits in aluOut.
//   done/zWrEn pulse for one cycle and drive the downstream zero-flag register.
//
//   Handshake: start is sampled only on a rising edge where the FSM is in IDLE
//   or FIN (busy==0). A start seen while busy==1 is dropped and not queued.
//   aluOut changes only on the edge that raises done.
//
//   Optional feature macro: ALU_DIV_EN. When it is defined, op 111 is an
//   unsigned restoring divide that returns the quotient only. When it is not
//   defined, op 111 is a single-cycle PASS A.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      op request, sampled when busy==0
//   op[2:0]    000 PASS A, 001 ADD, 010 SUB, 011 MUL, 100 INC A, 101 AND,
//              110 OR, 111 DIV or PASS A
//   aIn, bIn   operands A and B
//   busy       high while the FSM is iterating
//   done       one-cycle pulse after aluOut has been updated
//   zWrEn      copy of done, drives the zero-flag register write enable
//   aluOut     result register
//   dbg_state  current FSM state (0 IDLE, 1 ITER, 2 FIN)
module multicycle_alu #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic             busy,
  output logic             done,
  output logic             zWrEn,
  output logic [WIDTH-1:0] aluOut,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_zwr;
  logic [WIDTH-1:0] r_out;
  // Working registers, shared by the two iterative ops:
  //   MUL: r_acc = partial product, r_a = shifted multiplicand, r_b = shifted multiplier
  //   DIV: r_acc = remainder, r_a = dividend shifting out / quotient shifting in, r_b = divisor
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
`ifdef ALU_DIV_EN
  logic             r_div;
  logic [WIDTH:0]   w_rem_sh;
`endif

  logic             w_is_iter;
  logic [WIDTH-1:0] w_single;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_a_nx;
  logic [WIDTH-1:0] w_b_nx;
  logic [WIDTH-1:0] w_iter_res;

`ifdef ALU_DIV_EN
  assign w_is_iter = (op == OP_MUL) || (op == OP_DIV);
`else
  assign w_is_iter = (op == OP_MUL);
`endif

  // Result for single-cycle ops, taken straight from the operands at the accepting edge.
  always_comb begin
    w_single = aIn;
    case (op)
      OP_PASS: w_single = aIn;
      OP_ADD:  w_single = aIn + bIn;
      OP_SUB:  w_single = aIn - bIn;
      OP_INC:  w_single = aIn + WIDTH'(1);
      OP_AND:  w_single = aIn & bIn;
      OP_OR:   w_single = aIn | bIn;
      default: w_single = aIn;
    endcase
  end

  // One iteration step of the multiply or the divide.
  always_comb begin
    w_acc_nx   = r_acc;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
`ifdef ALU_DIV_EN
    w_rem_sh   = {r_acc, r_a[WIDTH-1]};
    if (r_div) begin
      // Restoring step. With a zero divisor the subtract always succeeds,
      // so the quotient comes out as all ones.
      if (w_rem_sh >= {1'b0, r_b}) begin
        w_acc_nx = w_rem_sh[WIDTH-1:0] - r_b;
        w_a_nx   = {r_a[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nx = w_rem_sh[WIDTH-1:0];
        w_a_nx   = {r_a[WIDTH-2:0], 1'b0};
      end
      w_iter_res = w_a_nx;
    end else
`endif
    begin
      // Shift-add with the LSB of B first.
      if (r_b[0]) w_acc_nx = r_acc + r_a;
      w_a_nx     = r_a << 1;
      w_b_nx     = r_b >> 1;
      w_iter_res = w_acc_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zwr   <= 1'b0;
      r_out   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
`ifdef ALU_DIV_EN
      r_div   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_zwr  <= 1'b0;
      case (r_state)
        IDLE, FIN: begin
          // FIN accepts start as well, so ops can run back to back.
          if (start) begin
            if (w_is_iter) begin
              r_state <= ITER;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_acc   <= '0;
              r_a     <= aIn;
              r_b     <= bIn;
`ifdef ALU_DIV_EN
              r_div   <= (op == OP_DIV);
`endif
            end else begin
              r_state <= FIN;
              r_out   <= w_single;
              r_done  <= 1'b1;
              r_zwr   <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        ITER: begin
          r_acc <= w_acc_nx;
          r_a   <= w_a_nx;
          r_b   <= w_b_nx;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_out   <= w_iter_res;
            r_done  <= 1'b1;
            r_zwr   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign zWrEn     = r_zwr;
  assign aluOut    = r_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu
//   Table-driven bench for multicycle_alu (WIDTH=12), plus hand-written
//   sequences for ignored start, start in FIN, and reset mid-operation.
//   A small zero-flag register model is fed from aluOut/zWrEn.
module tb_multicycle_alu;

  localparam int W = 12;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic         busy;
  logic         done;
  logic         zWrEn;
  logic [W-1:0] aluOut;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .aIn       (aIn),
    .bIn       (bIn),
    .busy      (busy),
    .done      (done),
    .zWrEn     (zWrEn),
    .aluOut    (aluOut),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Zero-flag register downstream of the ALU.
  logic zref;
  always @(posedge clk) begin
    if (rst)        zref <= 1'b0;
    else if (zWrEn) zref <= (aluOut == '0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one op from an idle/FIN cycle (called at posedge+#1) and wait for done.
  // lat counts cycles from the accepting edge to the done-high cycle, 1-based.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat, output int bcnt,
                        output logic zwr);
    start = 1'b1; op = o; aIn = a; bIn = b;
    @(posedge clk); #1;
    start = 1'b0;
    aIn = W'($urandom_range(0, 4095));
    bIn = W'($urandom_range(0, 4095));
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = aluOut;
    zwr = zWrEn;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  logic [W-1:0] res;
  logic         zwr;
  int           lat;
  int           bcnt;
  int           n;
  int           dseen;

  initial begin
    // ---------------- vector table ----------------
    vecs[0]  = '{OP_ADD,  12'd4095, 12'd1,    12'd0,    1};
    vecs[1]  = '{OP_SUB,  12'd5,    12'd3,    12'd2,    1};
    vecs[2]  = '{OP_SUB,  12'd0,    12'd1,    12'd4095, 1};
    vecs[3]  = '{OP_INC,  12'd4095, 12'd77,   12'd0,    1};
    vecs[4]  = '{OP_PASS, 12'd1234, 12'd999,  12'd1234, 1};
    vecs[5]  = '{OP_AND,  12'hF0F,  12'h0FF,  12'h00F,  1};
    vecs[6]  = '{OP_OR,   12'hF00,  12'h00F,  12'hF0F,  1};
    vecs[7]  = '{OP_ADD,  12'd1000, 12'd2000, 12'd3000, 1};
    vecs[8]  = '{OP_MUL,  12'd13,   12'd11,   12'd143,  13};
    vecs[9]  = '{OP_MUL,  12'd100,  12'd100,  12'd1808, 13};
    vecs[10] = '{OP_MUL,  12'd4095, 12'd4095, 12'd1,    13};
`ifdef ALU_DIV_EN
    vecs[11] = '{OP_DIV,  12'd100,  12'd7,    12'd14,   13};
    vecs[12] = '{OP_DIV,  12'd9,    12'd0,    12'd4095, 13};
`else
    vecs[11] = '{OP_DIV,  12'd9,    12'd5,    12'd9,    1};
    vecs[12] = '{OP_DIV,  12'd4000, 12'd0,    12'd4000, 1};
`endif

    // ---------------- reset, start held during reset ----------------
    rst = 1'b1; start = 1'b1; op = OP_ADD; aIn = 12'd5; bIn = 12'd6;
    dseen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dseen++;
    end
    rst = 1'b0; start = 1'b0;
    check("reset busy",   busy,   0);
    check("reset done",   done,   0);
    check("reset zWrEn",  zWrEn,  0);
    check("reset aluOut", aluOut, 0);
    check("reset state",  dbg_state, 0);
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dseen++;
    end
    check("start during reset ignored", dseen, 0);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt, zwr);
      check($sformatf("vec%0d result", i),  res,  vecs[i].exp);
      check($sformatf("vec%0d latency", i), lat,  vecs[i].lat);
      check($sformatf("vec%0d busy cycles", i), bcnt, vecs[i].lat - 1);
      check($sformatf("vec%0d zWrEn", i),   zwr,  1);
      @(posedge clk); #1;
      check($sformatf("vec%0d done pulse", i), done, 0);
      check($sformatf("vec%0d hold", i),    aluOut, vecs[i].exp);
      check($sformatf("vec%0d zReg", i),    zref, (vecs[i].exp == '0));
    end

    // ---------------- start ignored while busy, then start in FIN ----------------
    start = 1'b1; op = OP_MUL; aIn = 12'd13; bIn = 12'd11;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (n == 5) begin
        start = 1'b1; op = OP_INC; aIn = 12'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("busy-start latency", n, 13);
    check("busy-start result", aluOut, 143);
    // done is high here: this is the FIN cycle.
    start = 1'b1; op = OP_INC; aIn = 12'd7; bIn = 12'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("FIN start done", done, 1);
    check("FIN start result", aluOut, 8);
    @(posedge clk); #1;
    check("FIN start pulse end", done, 0);

    // ---------------- reset in the middle of a MUL ----------------
    start = 1'b1; op = OP_MUL; aIn = 12'd100; bIn = 12'd100;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy",   busy,   0);
    check("abort done",   done,   0);
    check("abort aluOut", aluOut, 0);
    check("abort state",  dbg_state, 0);
    dseen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) dseen++;
    end
    check("abort no done", dseen, 0);
    run_op(OP_ADD, 12'd2, 12'd2, res, lat, bcnt, zwr);
    check("post-abort result",  res, 4);
    check("post-abort latency", lat, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
